// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder. The sub signal exists only when
// SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder, one bit per clock through a single full-adder cell, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b - cin, borrow on cout).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-2:0]   sum_sr_q;
   logic [WIDTH-1:0]   sum_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q, cout_q;
   logic               accept, last_bit;
   logic               sum_bit, carry_nxt, a_eff;
   logic [WIDTH-1:0]   sum_nxt;
`ifdef SERIAL_ADDER_SUB_EN
   logic               sub_q;
`endif

   // A borrow is the carry of the same cell with the minuend bit inverted.
`ifdef SERIAL_ADDER_SUB_EN
   assign a_eff = sub_q ? ~a_q[0] : a_q[0];
`else
   assign a_eff = a_q[0];
`endif
   assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_nxt = (a_eff & b_q[0]) | (a_eff & carry_q) | (b_q[0] & carry_q);
   assign sum_nxt   = {sum_bit, sum_sr_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d  = state_q;
      accept   = 1'b0;
      last_bit = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == LAST_CNT) begin
               last_bit = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            accept  = bus.start;
            state_d = bus.start ? SHIFT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Published sum/cout change only on the final bit, so partial results never show.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every datapath register is cleared here because reset must zero all internal state.
         a_q      <= '0;
         b_q      <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q    <= 1'b0;
`endif
      end else if (accept) begin
         a_q      <= bus.a;
         b_q      <= bus.b;
         carry_q  <= bus.cin;
         sum_sr_q <= '0;
         cnt_q    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q    <= bus.sub;
`endif
      end else if (state_q == SHIFT) begin
         a_q      <= a_q >> 1;
         b_q      <= b_q >> 1;
         carry_q  <= carry_nxt;
         sum_sr_q <= sum_nxt[WIDTH-1:1];
         cnt_q    <= cnt_q + 1'b1;
         if (last_bit) begin
            sum_q  <= sum_nxt;
            cout_q <= carry_nxt;
         end
      end
   end

   assign bus.busy = (state_q == SHIFT);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8; subtract vectors run only
// when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   logic [W-1:0] last_sum;
   logic         last_cout;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts one operation right away, checks every busy cycle, the done cycle and the one after.
   task automatic test_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input string name);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 0; c < W; c++) begin
         vectors++;
         if ({bus.busy, bus.done, bus.cout, bus.sum} !== {1'b1, 1'b0, last_cout, last_sum}) begin
            miscompares++;
            $display("FAIL %s busy-cycle %0d: busy/done/cout/sum got %b/%b/%b/%h want 1/0/%b/%h",
                     name, c, bus.busy, bus.done, bus.cout, bus.sum, last_cout, last_sum);
         end
         @(posedge clk); #1;
      end
      vectors++;
      if ({bus.busy, bus.done, bus.cout, bus.sum} !== {1'b0, 1'b1, exp_cout, exp_sum}) begin
         miscompares++;
         $display("FAIL %s result: busy/done/cout/sum got %b/%b/%b/%h want 0/1/%b/%h",
                  name, bus.busy, bus.done, bus.cout, bus.sum, exp_cout, exp_sum);
      end
      last_sum  = exp_sum;
      last_cout = exp_cout;
      @(posedge clk); #1;
      vectors++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         miscompares++;
         $display("FAIL %s after-done: busy/done got %b/%b want 0/0", name, bus.busy, bus.done);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = 1'b0;
`endif
      last_sum  = '0;
      last_cout = 1'b0;
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
         miscompares++;
         $display("FAIL reset: busy/done/cout/sum got %b/%b/%b/%h want all 0",
                  bus.busy, bus.done, bus.cout, bus.sum);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         vectors++;
         if ({bus.busy, bus.done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset-idle %0d: busy/done got %b/%b want 0/0", c, bus.busy, bus.done);
         end
      end
   endtask

   task automatic test_add();
      test_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, "add_3c_05");
      test_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
      test_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
      test_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "add_00_00_c");
      test_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, "add_aa_55");
      test_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "add_80_80");
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      bus.sub = 1'b1;
      test_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, "sub_05_07");
      test_op(8'h07, 8'h05, 1'b0, 8'h02, 1'b0, "sub_07_05");
      test_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "sub_00_00_b");
      bus.sub = 1'b0;
   endtask
`endif

   // start re-asserted on the 4th busy cycle with other operands must be ignored.
   task automatic test_busy_ignore();
      logic want_busy, want_done;
      bus.start = 1'b1;
      bus.a     = 8'h12;
      bus.b     = 8'h34;
      bus.cin   = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int n = 1; n <= 18; n++) begin
         @(posedge clk); #1;
         want_busy = (n < W);
         want_done = (n == W);
         vectors++;
         if ({bus.busy, bus.done} !== {want_busy, want_done}) begin
            miscompares++;
            $display("FAIL busy_ignore cycle %0d: busy/done got %b/%b want %b/%b",
                     n, bus.busy, bus.done, want_busy, want_done);
         end
         if (n == W) begin
            vectors++;
            if ({bus.cout, bus.sum} !== {1'b0, 8'h46}) begin
               miscompares++;
               $display("FAIL busy_ignore result: cout/sum got %b/%h want 0/46", bus.cout, bus.sum);
            end
         end
         if (n == 3) begin
            bus.start = 1'b1;
            bus.a     = 8'hFF;
            bus.b     = 8'hFF;
            bus.cin   = 1'b1;
         end else if (n == 4) begin
            bus.start = 1'b0;
         end
      end
      last_sum  = 8'h46;
      last_cout = 1'b0;
   endtask

   // start held for 20 edges: accepted at edges 0, 9 and 18, done after 8, 17 and 26.
   task automatic test_back_to_back();
      logic [W-1:0] exp_sum [3];
      logic         want_busy, want_done;
      int           k;
      exp_sum = '{8'h10, 8'h55, 8'h98};
      k = 0;
      for (int n = 0; n <= 27; n++) begin
         if (n < 20) begin
            bus.start = 1'b1;
            bus.a     = 8'(n * 29 + 'hC0);
            bus.b     = 8'(n * 7 + 'h50);
            bus.cin   = 1'(n & 1);
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         want_done = (n == 8) || (n == 17) || (n == 26);
         want_busy = (n <= 25) && (n != 8) && (n != 17);
         vectors++;
         if ({bus.busy, bus.done} !== {want_busy, want_done}) begin
            miscompares++;
            $display("FAIL back_to_back cycle %0d: busy/done got %b/%b want %b/%b",
                     n, bus.busy, bus.done, want_busy, want_done);
         end
         if (want_done) begin
            vectors++;
            if ({bus.cout, bus.sum} !== {1'b1, exp_sum[k]}) begin
               miscompares++;
               $display("FAIL back_to_back op %0d: cout/sum got %b/%h want 1/%h",
                        k, bus.cout, bus.sum, exp_sum[k]);
            end
            k++;
         end
      end
      last_sum  = 8'h98;
      last_cout = 1'b1;
   endtask

   // Reset during the 3rd busy cycle clears outputs at once; next start works on the first edge.
   task automatic test_reset_abort();
      bus.start = 1'b1;
      bus.a     = 8'h0F;
      bus.b     = 8'h01;
      bus.cin   = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
         miscompares++;
         $display("FAIL reset_abort immediate: busy/done/cout/sum got %b/%b/%b/%h want all 0",
                  bus.busy, bus.done, bus.cout, bus.sum);
      end
      @(posedge clk); #1;
      vectors++;
      if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
         miscompares++;
         $display("FAIL reset_abort held: busy/done/cout/sum got %b/%b/%b/%h want all 0",
                  bus.busy, bus.done, bus.cout, bus.sum);
      end
      last_sum  = '0;
      last_cout = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      test_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "after_abort");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_add();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_busy_ignore();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
